// File: rtl/dmem_bus_bridge_pkg.sv
// dmem_bus_bridge_pkg: shared state encoding, lane helper and fault-cause codes for the dmem bus bridge
package dmem_bus_bridge_pkg;
   typedef enum logic [1:0] {DMB_IDLE, DMB_REQ, DMB_DONE} dmb_state_t;
   typedef enum logic [1:0] {FC_NONE, MISALIGN, BUS_ERR, TIMEOUT} dmb_fault_t;
   function automatic int dmb_lanes(input int dw);
      return dw / 8;
   endfunction
endpackage

// File: rtl/dmem_lane_mask.sv
// dmem_lane_mask: expands byte-lane enables into a per-bit mask
module dmem_lane_mask
   import dmem_bus_bridge_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [dmb_lanes(DATA_WIDTH)-1:0] be,
   output logic [DATA_WIDTH-1:0]            mask
);
   for (genvar i = 0; i < dmb_lanes(DATA_WIDTH); i++) begin : g_lane
      assign mask[8*i +: 8] = {8{be[i]}};
   end
endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns single-cycle CPU loads/stores into req/ack bus transactions,
// stalling the pipeline until completion and pulsing cpu_fault on misalign, bus error or timeout
module dmem_bus_bridge
   import dmem_bus_bridge_pkg::*;
#(
   parameter int          ADDR_WIDTH     = 32,
   parameter int          DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [ADDR_WIDTH-1:0]           cpu_addr,
   input  logic [DATA_WIDTH-1:0]           cpu_wdata,
   input  logic                            cpu_read,
   input  logic                            cpu_write,
   input  logic [dmb_lanes(DATA_WIDTH)-1:0] cpu_byte_enable,
   output logic [DATA_WIDTH-1:0]           cpu_rdata,
   output logic                            cpu_stall,
   output logic                            cpu_fault,
   output logic                            bus_req,
   output logic                            bus_we,
   output logic [ADDR_WIDTH-1:0]           bus_addr,
   output logic [DATA_WIDTH-1:0]           bus_wdata,
   output logic [dmb_lanes(DATA_WIDTH)-1:0] bus_be,
   input  logic                            bus_ack,
   input  logic [DATA_WIDTH-1:0]           bus_rdata,
   input  logic                            bus_err
);
   dmb_state_t              state;
   logic [31:0]             cnt;
   logic [DATA_WIDTH-1:0]   rmask;
   logic                    req, bad, tmo;
   dmem_lane_mask #(.DATA_WIDTH(DATA_WIDTH)) u_mask (.be(bus_be), .mask(rmask));
   assign req = cpu_read | cpu_write;
   assign bad = (cpu_addr[1:0] != 2'b00) || (cpu_byte_enable == '0);
   assign tmo = (TIMEOUT_CYCLES != 0) && (cnt + 32'd1 == TIMEOUT_CYCLES);
   // stall must assert in the request cycle itself, and drop with reset
   assign cpu_stall = reset && (state == DMB_REQ || (state == DMB_IDLE && req));
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= DMB_IDLE;
         cnt       <= '0;
         cpu_rdata <= '0;
         cpu_fault <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
      end else begin
         case (state)
            DMB_IDLE: if (req) begin
               bus_we    <= cpu_write;
               bus_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
               bus_wdata <= cpu_wdata;
               bus_be    <= cpu_byte_enable;
               cnt       <= '0;
               bus_req   <= !bad;
               cpu_fault <= bad;
               if (bad && !cpu_write) cpu_rdata <= '0;
               state     <= bad ? DMB_DONE : DMB_REQ;
            end
            DMB_REQ: begin
               cnt <= cnt + 32'd1;
               // an ack in the timeout cycle still completes normally
               if (bus_ack) begin
                  bus_req   <= 1'b0;
                  cpu_fault <= bus_err;
                  if (!bus_we) cpu_rdata <= bus_err ? '0 : (bus_rdata & rmask);
                  state     <= DMB_DONE;
               end else if (tmo) begin
                  bus_req   <= 1'b0;
                  cpu_fault <= 1'b1;
                  if (!bus_we) cpu_rdata <= '0;
                  state     <= DMB_DONE;
               end
            end
            default: begin
               cpu_fault <= 1'b0;
               state     <= DMB_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb_dmem_bus_bridge: randomized and directed checks of dmem_bus_bridge against a transaction-level model
module tb_dmem_bus_bridge;
   localparam int TMO = 4;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, bus_addr, bus_wdata, bus_rdata;
   logic        cpu_read, cpu_write, cpu_stall, cpu_fault;
   logic [3:0]  cpu_byte_enable, bus_be;
   logic        bus_req, bus_we, bus_ack, bus_err;
   int          n_chk = 0, n_pass = 0;
   logic [31:0] model_rd = '0;

   dmem_bus_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_byte_enable(cpu_byte_enable),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_fault(cpu_fault),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // d = wait states before ack; d >= TMO means the bus never answers in time
   task automatic run(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int d, input logic err, input logic [31:0] rdata);
      logic [31:0] m, erd;
      int ereq, estall, nreq, nstall;
      logic efault, done;
      m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
      if (addr[1:0] != 0 || be == 0) begin
         ereq = 0; estall = 1; efault = 1; erd = wr ? model_rd : 32'h0;
      end else if (d < TMO) begin
         ereq = d + 1; estall = d + 2; efault = err;
         erd = wr ? model_rd : (err ? 32'h0 : (rdata & m));
      end else begin
         ereq = TMO; estall = TMO + 1; efault = 1; erd = wr ? model_rd : 32'h0;
      end
      @(negedge clk);
      cpu_addr = addr; cpu_wdata = wdata; cpu_byte_enable = be; cpu_read = rd; cpu_write = wr;
      nreq = 0; nstall = 0; done = 0;
      for (int c = 0; c < 20 && !done; c++) begin
         bus_ack   = bus_req && (nreq == d);
         bus_err   = bus_ack ? err : 1'($urandom_range(0, 1));
         bus_rdata = bus_ack ? rdata : $urandom;
         #1;
         if (cpu_stall) begin
            nstall++;
            check("fault_early", {31'b0, cpu_fault}, 32'h0);
         end
         if (bus_req) begin
            nreq++;
            check("bus_addr", bus_addr, {addr[31:2], 2'b00});
            check("bus_we", {31'b0, bus_we}, {31'b0, wr});
            check("bus_be", {28'b0, bus_be}, {28'b0, be});
            if (wr) check("bus_wdata", bus_wdata, wdata);
         end
         if (!cpu_stall) begin
            done = 1;
            check("fault", {31'b0, cpu_fault}, {31'b0, efault});
            check("rdata", cpu_rdata, erd);
         end else @(negedge clk);
      end
      if (!done) check("done_timeout", 32'h0, 32'h1);
      check("stall_cycles", nstall, estall);
      check("req_cycles", nreq, ereq);
      model_rd = erd;
      bus_ack = 0; cpu_read = 0; cpu_write = 0;
   endtask

   initial begin
      logic [31:0] a;
      int op;
      reset = 0; cpu_addr = 0; cpu_wdata = 0; cpu_read = 0; cpu_write = 0; cpu_byte_enable = 0;
      bus_ack = 0; bus_rdata = 0; bus_err = 0;
      #12;
      check("rst_req", {31'b0, bus_req}, 32'h0);
      check("rst_stall", {31'b0, cpu_stall}, 32'h0);
      check("rst_fault", {31'b0, cpu_fault}, 32'h0);
      check("rst_rdata", cpu_rdata, 32'h0);
      check("rst_addr", bus_addr, 32'h0);
      check("rst_misc", {bus_wdata[27:0], bus_be}, 32'h0);
      @(negedge clk); reset = 1;
      run(1, 0, 32'h100, 0, 4'hF, 0, 0, 32'hDEADBEEF);
      run(0, 1, 32'h204, 32'h12345678, 4'h3, 3, 0, 32'hCAFEF00D);
      run(1, 0, 32'h102, 0, 4'hF, 0, 0, 32'h11111111);
      run(1, 0, 32'h108, 0, 4'hF, 9, 0, 32'h22222222);
      repeat (2) begin
         @(negedge clk); bus_ack = 1; bus_err = 0; bus_rdata = $urandom; #1;
         check("late_ack_req", {31'b0, bus_req}, 32'h0);
         check("late_ack_stall", {31'b0, cpu_stall}, 32'h0);
         check("late_ack_fault", {31'b0, cpu_fault}, 32'h0);
         @(posedge clk); #1;
         check("late_ack_rdata", cpu_rdata, model_rd);
      end
      bus_ack = 0;
      run(1, 0, 32'h10C, 0, 4'h1, 0, 1, 32'hFFFFFFFF);
      run(1, 0, 32'h10C, 0, 4'h1, 0, 0, 32'hFFFFFFFF);
      run(1, 1, 32'h110, 32'hA5A5A5A5, 4'hF, 1, 0, 32'h33333333);
      run(1, 0, 32'h114, 0, 4'h0, 0, 0, 32'h44444444);
      @(negedge clk);
      cpu_addr = 32'h300; cpu_byte_enable = 4'hF; cpu_read = 1; bus_ack = 0;
      @(negedge clk); @(negedge clk);
      check("pre_rst_req", {31'b0, bus_req}, 32'h1);
      #2 reset = 0; #1;
      check("async_rst_req", {31'b0, bus_req}, 32'h0);
      check("async_rst_stall", {31'b0, cpu_stall}, 32'h0);
      check("async_rst_rdata", cpu_rdata, 32'h0);
      model_rd = 0; cpu_read = 0;
      @(negedge clk); reset = 1;
      run(1, 0, 32'h400, 0, 4'hF, 0, 0, 32'h87654321);
      for (int t = 0; t < 60; t++) begin
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         op = $urandom_range(0, 2);
         run(op != 1, op != 0, a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 5),
             $urandom_range(0, 3) == 0, $urandom);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/dmem_bus_bridge.md
Name: dmem_bus_bridge

Overview:
Sits directly downstream of the CPU core's data-memory port (dmem_addr/dmem_data_out/dmem_read/dmem_write/dmem_byte_enable, returning dmem_data_in). Converts the core's single-cycle load/store request into a req/ack bus transaction with arbitrary wait states. Stalls the pipeline with cpu_stall until the transaction completes. Reports misaligned, bus-error and timeout conditions on cpu_fault.

Parameters:
ADDR_WIDTH, 32, byte address width on CPU and bus sides.
DATA_WIDTH, 32, data width; byte lanes = DATA_WIDTH/8.
TIMEOUT_CYCLES, 255, maximum number of REQ cycles before abort; 0 disables the timeout.

Ports:
clk  in  1  system clock, all state on the rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
cpu_addr  in  ADDR_WIDTH  load/store byte address
cpu_wdata  in  DATA_WIDTH  store data, already lane-aligned
cpu_read  in  1  load request
cpu_write  in  1  store request
cpu_byte_enable  in  DATA_WIDTH/8  lane enables
cpu_rdata  out  DATA_WIDTH  load data, registered; non-enabled lanes forced to 0
cpu_stall  out  1  pipeline hold request
cpu_fault  out  1  one-cycle pulse: access failed
bus_req  out  1  transaction request, held until ack or abort
bus_we  out  1  1 = write
bus_addr  out  ADDR_WIDTH  word-aligned address (low 2 bits always 0)
bus_wdata  out  DATA_WIDTH  write data
bus_be  out  DATA_WIDTH/8  lane enables
bus_ack  in  1  transaction complete, sampled while bus_req=1
bus_rdata  in  DATA_WIDTH  read data, valid with bus_ack
bus_err  in  1  error qualifier, valid with bus_ack

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; every output is 0; the timeout counter is 0. A reset during REQ drops bus_req immediately and discards the transaction.
- States: IDLE, REQ, DONE.
- IDLE:
  - When cpu_read|cpu_write=1, latch addr, wdata, be and we. If both requests are asserted, write wins and the same fault rules apply.
  - cpu_stall = cpu_read|cpu_write (combinational), asserted in this same cycle.
  - If cpu_addr[1:0]!=0 or cpu_byte_enable==0, skip the bus: go to DONE with a fault pending.
  - Otherwise go to REQ.
- REQ:
  - bus_req=1, and bus_we, bus_addr, bus_wdata and bus_be are held stable from the latched values; cpu_stall=1.
  - Counter increments each REQ cycle.
  - If bus_ack=1: for a read, capture bus_rdata masked by be into cpu_rdata. A fault is pending if bus_err=1. Go to DONE.
  - If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES with no ack: drop bus_req, set a fault pending, set cpu_rdata=0, go to DONE.
  - An ack in the same cycle as the timeout takes priority over the timeout.
- DONE:
  - cpu_stall=0, so the pipeline advances this cycle; cpu_fault = pending fault; cpu_rdata holds its value.
  - CPU request inputs are ignored, because they are still the completed request.
  - Always go to IDLE.
  - On a faulted read, cpu_rdata=0.
- Latency: with bus_ack in the first REQ cycle, the request is in cycle 0, REQ is cycle 1, DONE is cycle 2. cpu_stall is high for 2 cycles and data is visible in DONE. Each wait state adds one cycle.
- bus_ack or bus_err while bus_req=0 is ignored.
- cpu_rdata changes only on a read completion or on reset.

Decomposition:
- Shared constants package: the state encoding (DMB_IDLE, DMB_REQ, DMB_DONE), the lane count macro, and the fault-cause codes (MISALIGN, BUS_ERR, TIMEOUT) for a future debug port.
- One sub-module is natural: dmem_lane_mask, a combinational byte-enable expansion to a bit mask, reused for rdata masking.

Test Plan:
- Read addr 0x100, be=1111, bus acks on the 1st REQ cycle with 0xDEADBEEF -> bus_req high 1 cycle, bus_addr=0x100; cpu_stall high 2 cycles; cpu_rdata=0xDEADBEEF in DONE; no fault.
- Write addr 0x204, wdata 0x12345678, be=0011, ack after 3 wait states -> bus_we=1 and bus_be=0011 stable for 4 cycles; cpu_stall high 5 cycles; cpu_rdata unchanged.
- Read addr 0x102 -> no bus_req; cpu_stall high 1 cycle; cpu_fault pulses in DONE; cpu_rdata=0.
- Read with TIMEOUT_CYCLES=4 and no ack -> bus_req high exactly 4 cycles then drops; cpu_fault pulse; cpu_rdata=0; a late bus_ack afterwards is ignored.
- Read acked with bus_err=1, rdata 0xFFFFFFFF, be=0001 -> cpu_fault pulse; cpu_rdata=0. Repeat with bus_err=0 -> cpu_rdata=0x000000FF.
- Assert reset=0 mid-REQ -> bus_req and cpu_stall go to 0 asynchronously. After release, a new read completes normally in 3 cycles.
